// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory requester.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [31:0] BM_BYTE = 32'd0;
   localparam logic [31:0] BM_HALF = 32'd1;
   localparam logic [31:0] BM_WORD = 32'd2;

   // Memory manager only looks at [1:0]; the rest stays zero.
   function automatic logic [31:0] byte_mode(input logic [1:0] size);
      byte_mode = {30'b0, size};
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed lane out of a full read word and sign/zero-extends it.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] rdata
);

   logic [31:0] b_sh;
   logic [31:0] h_sh;

   always_comb begin
      b_sh  = data >> {addr, 3'b000};
      h_sh  = data >> {addr[1], 4'b0000};
      rdata = data;
      case (size)
         SZ_BYTE: rdata = {{24{sgn & b_sh[7]}}, b_sh[7:0]};
         SZ_HALF: rdata = {{16{sgn & h_sh[15]}}, h_sh[15:0]};
         default: rdata = data;
      endcase
   end

endmodule

// File: rtl/dmem_requester.sv
// MEM-stage initiator for the banked data memory: one outstanding load/store,
// fault screening at accept, registered memory-side outputs.
module dmem_requester
   import dmem_pkg::*;
#(
   parameter int BANK_LSB  = 18,
   parameter int BANK_BITS = 2,
   parameter int RD_LAT    = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] address_o,
   output logic [31:0] data_o,
   output logic        wren_o,
   output logic [31:0] byte_mode_o,
   input  logic [31:0] data_i
);

   localparam int HI = BANK_LSB + BANK_BITS;
   localparam int CW = $clog2(RD_LAT + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          l_we;
   logic [1:0]    l_size;
   logic          l_sgn;
   logic [1:0]    l_addr;
   logic [31:0]   ld_rdata;

   function automatic logic fault(input logic [1:0] size, input logic [31:0] addr);
      logic [31:0] hi_bits;
      hi_bits = addr >> HI;
      fault = (size == 2'd3)
           || (size == SZ_HALF && addr[0])
           || (size == SZ_WORD && addr[1:0] != 2'b00)
           || (hi_bits != 32'd0);
   endfunction

   dmem_load_align u_align (
      .data  (data_i),
      .addr  (l_addr),
      .size  (l_size),
      .sgn   (l_sgn),
      .rdata (ld_rdata)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state        <= IDLE;
         cnt          <= '0;
         l_we         <= 1'b0;
         l_size       <= 2'b00;
         l_sgn        <= 1'b0;
         l_addr       <= 2'b00;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= 32'd0;
         resp_err_o   <= 1'b0;
         address_o    <= 32'd0;
         data_o       <= 32'd0;
         wren_o       <= 1'b0;
         byte_mode_o  <= 32'd0;
      end else begin
         case (state)
            IDLE: if (req_valid_i) begin
               l_we        <= req_we_i;
               l_size      <= req_size_i;
               l_sgn       <= req_signed_i;
               l_addr      <= req_addr_i[1:0];
               req_ready_o <= 1'b0;
               // Faulting requests never touch the memory-side outputs.
               if (fault(req_size_i, req_addr_i)) begin
                  state        <= RESP;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b1;
                  resp_rdata_o <= 32'd0;
               end else begin
                  state       <= ISSUE;
                  address_o   <= req_addr_i;
                  data_o      <= req_wdata_i;
                  byte_mode_o <= byte_mode(req_size_i);
                  wren_o      <= req_we_i;
               end
            end
            ISSUE: begin
               wren_o <= 1'b0;
               if (l_we) begin
                  state        <= RESP;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b0;
                  resp_rdata_o <= 32'd0;
               end else begin
                  state <= WAIT;
                  cnt   <= CW'(RD_LAT - 1);
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state        <= RESP;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b0;
                  resp_rdata_o <= ld_rdata;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: if (resp_ready_i) begin
               state        <= IDLE;
               resp_valid_o <= 1'b0;
               req_ready_o  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_requester.sv
// Bench for dmem_requester: directed vector table, multi-cycle sequences and
// random traffic against a reference model, on RD_LAT=1 and RD_LAT=3 instances.
module tb_dmem_requester;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;
   logic RST;

   logic        req_valid[2], req_we[2], req_signed[2], resp_ready[2];
   logic [1:0]  req_size[2];
   logic [31:0] req_addr[2], req_wdata[2], data_i[2];

   logic        req_ready[2], resp_valid[2], resp_err[2], wren[2];
   logic [31:0] resp_rdata[2], address[2], data_o[2], byte_mode[2];

   logic        a_rr, a_rv, a_re, a_wr, b_rr, b_rv, b_re, b_wr;
   logic [31:0] a_rd, a_ad, a_do, a_bm, b_rd, b_ad, b_do, b_bm;

   dmem_requester #(.BANK_LSB(18), .BANK_BITS(2), .RD_LAT(1)) dut_a (
      .CLK(CLK), .RST(RST),
      .req_valid_i(req_valid[0]), .req_ready_o(a_rr), .req_we_i(req_we[0]),
      .req_size_i(req_size[0]), .req_signed_i(req_signed[0]), .req_addr_i(req_addr[0]),
      .req_wdata_i(req_wdata[0]), .resp_valid_o(a_rv), .resp_ready_i(resp_ready[0]),
      .resp_rdata_o(a_rd), .resp_err_o(a_re), .address_o(a_ad), .data_o(a_do),
      .wren_o(a_wr), .byte_mode_o(a_bm), .data_i(data_i[0])
   );

   dmem_requester #(.BANK_LSB(18), .BANK_BITS(2), .RD_LAT(3)) dut_b (
      .CLK(CLK), .RST(RST),
      .req_valid_i(req_valid[1]), .req_ready_o(b_rr), .req_we_i(req_we[1]),
      .req_size_i(req_size[1]), .req_signed_i(req_signed[1]), .req_addr_i(req_addr[1]),
      .req_wdata_i(req_wdata[1]), .resp_valid_o(b_rv), .resp_ready_i(resp_ready[1]),
      .resp_rdata_o(b_rd), .resp_err_o(b_re), .address_o(b_ad), .data_o(b_do),
      .wren_o(b_wr), .byte_mode_o(b_bm), .data_i(data_i[1])
   );

   always_comb begin
      req_ready[0] = a_rr;  req_ready[1] = b_rr;
      resp_valid[0] = a_rv; resp_valid[1] = b_rv;
      resp_err[0] = a_re;   resp_err[1] = b_re;
      wren[0] = a_wr;       wren[1] = b_wr;
      resp_rdata[0] = a_rd; resp_rdata[1] = b_rd;
      address[0] = a_ad;    address[1] = b_ad;
      data_o[0] = a_do;     data_o[1] = b_do;
      byte_mode[0] = a_bm;  byte_mode[1] = b_bm;
   end

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int lat[2];
   logic [31:0] last_addr[2];

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (cyc > 50000) begin
         $display("FAIL watchdog: cycles=%0d limit=50000", cyc);
         $fatal(1, "watchdog expired");
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
      longint unsigned ua = a;
      return (sz == 3) || (sz == 1 && ua % 2 != 0) || (sz == 2 && ua % 4 != 0)
          || (ua >= 64'd1048576);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic sg);
      longint v;
      longint ww = longint'(w);
      longint lane = longint'(a % 4);
      if (sz == 0) begin
         v = (ww / (64'sd1 << (8 * lane))) % 256;
         if (sg && v > 127) v = v - 256;
      end else if (sz == 1) begin
         v = (ww / (64'sd1 << (8 * (lane / 2) * 2))) % 65536;
         if (sg && v > 32767) v = v - 65536;
      end else begin
         v = ww;
      end
      return v[31:0];
   endfunction

   // Runs one request from an idle negedge to the negedge after the handshake.
   task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                      input logic eerr, input logic [31:0] erd, input int stall);
      chk("ready_idle", req_ready[d], 32'd1);
      req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz; req_signed[d] = sg;
      req_addr[d] = a; req_wdata[d] = wd; data_i[d] = $urandom;
      @(negedge CLK);
      req_valid[d] = 1'b0; req_we[d] = $urandom; req_size[d] = 2'($urandom);
      req_signed[d] = $urandom; req_addr[d] = $urandom; req_wdata[d] = $urandom;
      chk("ready_busy", req_ready[d], 32'd0);
      if (eerr) begin
         chk("fault_wren", wren[d], 32'd0);
         chk("fault_addr_held", address[d], last_addr[d]);
      end else begin
         chk("issue_wren", wren[d], we);
         chk("issue_addr", address[d], a);
         chk("issue_bmode", byte_mode[d], {30'b0, sz});
         if (we) chk("issue_wdata", data_o[d], wd);
         chk("issue_no_resp", resp_valid[d], 32'd0);
         last_addr[d] = a;
         if (!we) begin
            for (int c = 1; c <= lat[d]; c++) begin
               @(negedge CLK);
               chk("wait_no_resp", resp_valid[d], 32'd0);
               chk("wait_wren", wren[d], 32'd0);
               data_i[d] = (c == lat[d]) ? rw : $urandom;
            end
         end
         @(negedge CLK);
         data_i[d] = $urandom;
         chk("post_wren", wren[d], 32'd0);
      end
      chk("resp_valid", resp_valid[d], 32'd1);
      chk("resp_err", resp_err[d], eerr);
      chk("resp_rdata", resp_rdata[d], erd);
      for (int s = 0; s < stall; s++) begin
         resp_ready[d] = 1'b0;
         @(negedge CLK);
         chk("stall_valid", resp_valid[d], 32'd1);
         chk("stall_rdata", resp_rdata[d], erd);
         chk("stall_err", resp_err[d], eerr);
         chk("stall_ready", req_ready[d], 32'd0);
      end
      resp_ready[d] = 1'b1;
      @(negedge CLK);
      resp_ready[d] = 1'b0;
      chk("done_valid", resp_valid[d], 32'd0);
      chk("done_ready", req_ready[d], 32'd1);
   endtask

   typedef struct {
      int          d;
      logic        we;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rw;
      logic        eerr;
      logic [31:0] erd;
      int          stall;
   } vec_t;

   vec_t tbl[$];

   initial begin
      lat[0] = 1; lat[1] = 3;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 0; req_we[d] = 0; req_size[d] = 0; req_signed[d] = 0;
         req_addr[d] = 0; req_wdata[d] = 0; data_i[d] = 0; resp_ready[d] = 0;
         last_addr[d] = 0;
      end
      RST = 1'b0;
      @(negedge CLK); @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", req_ready[d], 32'd1);
         chk("rst_resp_valid", resp_valid[d], 32'd0);
         chk("rst_wren", wren[d], 32'd0);
         chk("rst_addr", address[d], 32'd0);
         chk("rst_data", data_o[d], 32'd0);
         chk("rst_bmode", byte_mode[d], 32'd0);
      end
      RST = 1'b1;
      @(negedge CLK);

      //          d we sz sg addr          wdata         rdword        err rdata         stall
      tbl.push_back('{0, 1, 2, 0, 32'h00040010, 32'hDEADBEEF, 32'h0,        0, 32'h00000000, 0});
      tbl.push_back('{0, 0, 0, 1, 32'h00000003, 32'h0,        32'h80FF7F01, 0, 32'hFFFFFF80, 0});
      tbl.push_back('{0, 0, 0, 0, 32'h00000003, 32'h0,        32'h80FF7F01, 0, 32'h00000080, 0});
      tbl.push_back('{0, 0, 1, 0, 32'h00000001, 32'h0,        32'h0,        1, 32'h00000000, 0});
      tbl.push_back('{0, 0, 3, 0, 32'h00000000, 32'h0,        32'h0,        1, 32'h00000000, 1});
      tbl.push_back('{0, 0, 2, 0, 32'h00100000, 32'h0,        32'h0,        1, 32'h00000000, 0});
      tbl.push_back('{0, 1, 0, 0, 32'h80000004, 32'h55,       32'h0,        1, 32'h00000000, 0});
      tbl.push_back('{0, 0, 1, 1, 32'h00000002, 32'h0,        32'h80FF7F01, 0, 32'hFFFF80FF, 5});
      tbl.push_back('{0, 0, 0, 0, 32'h00000001, 32'h0,        32'h80FF7F01, 0, 32'h0000007F, 0});
      tbl.push_back('{0, 0, 0, 1, 32'h00000002, 32'h0,        32'h80FF7F01, 0, 32'hFFFFFFFF, 0});
      tbl.push_back('{0, 0, 1, 1, 32'h000FFFFC, 32'h0,        32'h12347FFF, 0, 32'h00007FFF, 2});
      tbl.push_back('{1, 0, 2, 0, 32'h0003FFFC, 32'h0,        32'h12345678, 0, 32'h12345678, 0});
      tbl.push_back('{1, 1, 1, 0, 32'h00000102, 32'hCAFE,     32'h0,        0, 32'h00000000, 0});
      tbl.push_back('{1, 0, 0, 1, 32'h00000100, 32'h0,        32'h000000F0, 0, 32'hFFFFFFF0, 3});
      foreach (tbl[i])
         txn(tbl[i].d, tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, tbl[i].rw,
             tbl[i].eerr, tbl[i].erd, tbl[i].stall);

      // Reset while the slow instance sits in WAIT: request is dropped silently.
      req_valid[1] = 1; req_we[1] = 0; req_size[1] = 2; req_signed[1] = 0;
      req_addr[1] = 32'h00000200;
      @(negedge CLK);
      req_valid[1] = 0;
      @(negedge CLK);
      chk("pre_rst_busy", req_ready[1], 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      chk("midrst_ready", req_ready[1], 32'd1);
      chk("midrst_valid", resp_valid[1], 32'd0);
      chk("midrst_wren", wren[1], 32'd0);
      chk("midrst_addr", address[1], 32'd0);
      last_addr[0] = 0; last_addr[1] = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         chk("midrst_no_resp", resp_valid[1], 32'd0);
      end
      txn(1, 1'b1, 2'd2, 1'b0, 32'h00000040, 32'hA5A5A5A5, 32'h0, 1'b0, 32'h0, 0);

      // Random traffic, stores and loads alternating, on both instances.
      for (int n = 0; n < 80; n++) begin
         int d;
         logic we, sg;
         logic [1:0] sz;
         logic [31:0] a, wd, rw;
         logic ee;
         d  = n % 2;
         we = ((n / 2) % 2) == 0;
         sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom);
         a  = $urandom_range(0, 32'h000FFFFF);
         if ($urandom_range(0, 1) == 1) a = a & ~32'(sz == 1 ? 1 : (sz == 2 ? 3 : 0));
         if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(20, 31));
         wd = $urandom;
         rw = $urandom;
         ee = ref_fault(sz, a);
         txn(d, we, sz, sg, a, wd, rw, ee,
             (ee || we) ? 32'd0 : ref_load(rw, a, sz, sg), $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
